rifl_err_apply: RTL and testbench
=================================

// Module: rifl_err_apply
// PURPOSE
//  Downstream consumer of the per-bit error vector from the RIFL error injector.
//  XORs err_vec into an AXI-Stream data path on accepted beats; gated by off/continuous/burst FSM.
//  Sits on the TX lane between the framer and the serializer to emulate a noisy channel.
//  Reports injected-beat count; optional bit-error statistics.
// PARAMETERS
//  DWIDTH     64  data / error-vector width
//  CNT_WIDTH  32  width of statistics counters
//  BLEN_W     16  width of burst_len
// PORTS
//  clk            in   1          sole clock, all logic rising-edge
//  rst            in   1          synchronous, active-high reset
//  s_axis_tdata   in   DWIDTH     upstream data
//  s_axis_tvalid  in   1          upstream valid
//  s_axis_tready  out  1          upstream ready
//  m_axis_tdata   out  DWIDTH     data with errors applied
//  m_axis_tvalid  out  1          downstream valid
//  m_axis_tready  in   1          downstream ready
//  err_vec        in   DWIDTH     error mask from injector, new value every cycle
//  mode           in   2          00 off, 01 continuous, 10 burst, 11 reserved (= off)
//  start          in   1          one-cycle pulse, arms a burst in mode 10
//  burst_len      in   BLEN_W     beats to corrupt per burst
//  clear_cnt      in   1          synchronous clear of statistics counters
//  busy           out  1          FSM not in IDLE
//  inj_beats      out  CNT_WIDTH  accepted beats with >=1 flipped bit (saturating)
//  inj_bits       out  CNT_WIDTH  total flipped bits (saturating), only with RIFL_ERR_STATS_EN
// BEHAVIOUR
//  - Reset: m_axis_tvalid=0, m_axis_tdata=0, busy=0, inj_beats=0, inj_bits=0, FSM=IDLE, remaining=0.
//  - Pipeline: one output register. s_axis_tready = !m_axis_tvalid || m_axis_tready (comb).
//  - accept = s_axis_tvalid && s_axis_tready; on accept m_axis_tdata <= s_axis_tdata ^ (err_vec & {DWIDTH{inj_en}}).
//  - Latency 1 cycle. No beat dropped/duplicated under arbitrary backpressure. tdata stable while stalled.
//  - err_vec sampled in the accept cycle; err_vec in non-accept cycles is discarded.
//  - inj_en = (state==CONT) || (state==BURST); combinational from current state.
//  - FSM states IDLE, CONT, BURST:
//    IDLE : mode==01 -> CONT; mode==10 && start && burst_len!=0 -> BURST, remaining<=burst_len.
//           start with burst_len==0 -> stay IDLE, no injection.
//    CONT : mode!=01 -> IDLE. Beats accepted in the exit cycle are still corrupted.
//    BURST: accept -> remaining-1; accept && remaining==1 -> IDLE.
//           mode!=10 -> IDLE (abort; remaining<=0). start while in BURST ignored.
//  - busy = (state!=IDLE).
//  - inj_beats += 1 on accept && inj_en && |err_vec; saturates at all-ones.
//  - clear_cnt has priority over increment in the same cycle. rst clears all state; a burst in progress is lost.
// CONFIGURATION
//  - RIFL_ERR_STATS_EN defined: inj_bits += popcount(err_vec & mask) on accept.
//    Adder is CNT_WIDTH wide, saturates at all-ones; cleared by clear_cnt/rst.
//  - Undefined: no popcount logic; inj_bits tied to 0; port still present.
// STRUCTURE
//  - Package rifl_err_pkg: mode_e {MODE_OFF=2'b00, MODE_CONT=2'b01, MODE_BURST=2'b10};
//    state_e {ST_IDLE, ST_CONT, ST_BURST}.
//  - Package also holds a function sat_add(a,b) for saturating counter increments.
//  - Sub-module rifl_popcnt #(DWIDTH): combinational popcount, instantiated only under RIFL_ERR_STATS_EN.
// TESTING
//  - mode=00, stream 0..99, err_vec=all-ones -> output == input bit-exact, inj_beats=0, busy=0.
//  - mode=01, err_vec=64'h1 per beat, tready random 50% -> every out = in^1; 100 beats -> inj_beats=100.
//  - mode=10, burst_len=5, start, err_vec=64'hFF -> exactly beats 1..5 after start flipped (low byte).
//    busy drops after beat 5; inj_bits=40 with macro.
//  - mode=10, burst_len=0, start -> busy stays 0, no beat corrupted.
//  - Burst of 10, mode->00 after 3 accepted beats -> 3 corrupted, then clean; busy=0 next cycle.
//  - Preload inj_beats to 2^CNT_WIDTH-2 (CNT_WIDTH=2 build), 5 corrupted beats -> saturates at 3.
//    clear_cnt with a simultaneous corrupted beat -> 0.

Source files
------------

// File: rtl/rifl_err_pkg.sv
// Shared types and helpers for the RIFL error-apply stage.
package rifl_err_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_CONT  = 2'b01,
        MODE_BURST = 2'b10
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONT,
        ST_BURST
    } state_e;

    localparam int unsigned SAT_MAX_W = 64;

    // Saturating add of two counters that are 'width' bits wide (width <= 64).
    // 'a' is assumed already within range; the result clamps at 2**width-1.
    function automatic logic [SAT_MAX_W-1:0] sat_add(
        input logic [SAT_MAX_W-1:0] a,
        input logic [SAT_MAX_W-1:0] b,
        input int unsigned          width
    );
        logic [SAT_MAX_W:0] sum;
        logic [SAT_MAX_W:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        if (width >= SAT_MAX_W)
            lim = {1'b0, {SAT_MAX_W{1'b1}}};
        else
            lim = (65'd1 << width) - 65'd1;
        if (sum > lim)
            return lim[SAT_MAX_W-1:0];
        return sum[SAT_MAX_W-1:0];
    endfunction

endpackage

// File: rtl/rifl_popcnt.sv
// Combinational population count of a DWIDTH-bit vector.
module rifl_popcnt #(
    parameter int unsigned DWIDTH = 64,
    parameter int unsigned CW     = $clog2(DWIDTH + 1)
) (
    input  logic [DWIDTH-1:0] din,
    output logic [CW-1:0]     cnt
);

    // Ripple sum of all set bits.
    always_comb begin
        cnt = '0;
        for (int i = 0; i < int'(DWIDTH); i++)
            cnt = cnt + CW'(din[i]);
    end

endmodule

// File: rtl/rifl_err_apply.sv
// RIFL error apply: XORs the injector's error vector into accepted AXI-Stream
// beats under an off / continuous / burst gate and counts corrupted beats.
// Optional feature macro: RIFL_ERR_STATS_EN enables the flipped-bit counter
// inj_bits; without it the port is tied to zero.
module rifl_err_apply
    import rifl_err_pkg::*;
#(
    parameter int unsigned DWIDTH    = 64,
    parameter int unsigned CNT_WIDTH = 32,
    parameter int unsigned BLEN_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DWIDTH-1:0]    s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    output logic [DWIDTH-1:0]    m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    input  logic [DWIDTH-1:0]    err_vec,
    input  logic [1:0]           mode,
    input  logic                 start,
    input  logic [BLEN_W-1:0]    burst_len,
    input  logic                 clear_cnt,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] inj_beats,
    output logic [CNT_WIDTH-1:0] inj_bits
);

    state_e              state_q, state_d;
    logic [BLEN_W-1:0]   rem_q, rem_d;
    mode_e               mode_v;
    logic                accept;
    logic                inj_en;
    logic [DWIDTH-1:0]   mask;

    assign mode_v        = mode_e'(mode);
    assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign inj_en        = (state_q == ST_CONT) || (state_q == ST_BURST);
    assign mask          = err_vec & {DWIDTH{inj_en}};

    // Gate state and remaining-burst register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            busy    <= (state_d != ST_IDLE);
        end
    end

    // Next-state: mode selects the gate; a burst ends on its last beat or on abort.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        case (state_q)
            ST_IDLE: begin
                if (mode_v == MODE_CONT) begin
                    state_d = ST_CONT;
                end else if (mode_v == MODE_BURST && start && burst_len != '0) begin
                    state_d = ST_BURST;
                    rem_d   = burst_len;
                end
            end
            ST_CONT: begin
                if (mode_v != MODE_CONT)
                    state_d = ST_IDLE;
            end
            ST_BURST: begin
                if (mode_v != MODE_BURST) begin
                    state_d = ST_IDLE;
                    rem_d   = '0;
                end else if (accept) begin
                    rem_d = rem_q - BLEN_W'(1);
                    if (rem_q == BLEN_W'(1))
                        state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                rem_d   = '0;
            end
        endcase
    end

    // Single output register; holds its beat while the sink stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
        end else if (s_axis_tready) begin
            m_axis_tvalid <= s_axis_tvalid;
            if (accept)
                m_axis_tdata <= s_axis_tdata ^ mask;
        end
    end

    // Corrupted-beat counter; clear wins over increment.
    always_ff @(posedge clk) begin
        if (rst || clear_cnt)
            inj_beats <= '0;
        else if (accept && inj_en && (|err_vec))
            inj_beats <= CNT_WIDTH'(sat_add(64'(inj_beats), 64'd1, CNT_WIDTH));
    end

`ifdef RIFL_ERR_STATS_EN
    localparam int unsigned PCW = $clog2(DWIDTH + 1);
    logic [PCW-1:0] pop_cnt;

    rifl_popcnt #(
        .DWIDTH (DWIDTH),
        .CW     (PCW)
    ) u_popcnt (
        .din (mask),
        .cnt (pop_cnt)
    );

    // Flipped-bit counter; clear wins over accumulation.
    always_ff @(posedge clk) begin
        if (rst || clear_cnt)
            inj_bits <= '0;
        else if (accept && inj_en)
            inj_bits <= CNT_WIDTH'(sat_add(64'(inj_bits), 64'(pop_cnt), CNT_WIDTH));
    end
`else
    assign inj_bits = '0;
`endif

endmodule

// File: tb/tb_rifl_err_apply.sv
// Self-checking bench for rifl_err_apply: a 32-bit-counter instance and a
// 2-bit-counter instance share one stimulus; an abstract model predicts both.
module tb_rifl_err_apply;

    localparam int unsigned DW = 64;
    localparam int unsigned BW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] err_vec;
    logic [1:0]    mode;
    logic          start;
    logic [BW-1:0] burst_len;
    logic          clear_cnt;
    logic          busy;
    logic [31:0]   inj_beats, inj_bits;

    logic          sm_s_ready, sm_m_valid, sm_busy;
    logic [DW-1:0] sm_m_data;
    logic [1:0]    sm_beats, sm_bits;

    int  checks = 0;
    int  errors = 0;
    bit  rand_ready = 1'b0;
    logic [DW-1:0] recv[$];

    always #5 clk = ~clk;

    rifl_err_apply #(.DWIDTH(DW), .CNT_WIDTH(32), .BLEN_W(BW)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_data), .s_axis_tvalid(s_valid), .s_axis_tready(s_ready),
        .m_axis_tdata(m_data), .m_axis_tvalid(m_valid), .m_axis_tready(m_ready),
        .err_vec(err_vec), .mode(mode), .start(start), .burst_len(burst_len),
        .clear_cnt(clear_cnt), .busy(busy), .inj_beats(inj_beats), .inj_bits(inj_bits)
    );

    rifl_err_apply #(.DWIDTH(DW), .CNT_WIDTH(2), .BLEN_W(BW)) dut_sm (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_data), .s_axis_tvalid(s_valid), .s_axis_tready(sm_s_ready),
        .m_axis_tdata(sm_m_data), .m_axis_tvalid(sm_m_valid), .m_axis_tready(m_ready),
        .err_vec(err_vec), .mode(mode), .start(start), .burst_len(burst_len),
        .clear_cnt(clear_cnt), .busy(sm_busy), .inj_beats(sm_beats), .inj_bits(sm_bits)
    );

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint sat(input longint v, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    // ---------------- abstract model ----------------
    bit            mdl_have;
    logic [DW-1:0] mdl_data;
    bit            mdl_cont;
    int            mdl_left;
    longint        mdl_beats, mdl_bits;

    always @(posedge clk) begin
        bit acc, inj;
        if (m_valid && m_ready) recv.push_back(m_data);
        if (rst) begin
            mdl_have = 0; mdl_data = '0; mdl_cont = 0; mdl_left = 0;
            mdl_beats = 0; mdl_bits = 0;
        end else begin
            acc = s_valid && (!mdl_have || m_ready);
            inj = mdl_cont || (mdl_left > 0);
            if (acc) begin
                mdl_data = s_data ^ (inj ? err_vec : '0);
                mdl_have = 1;
            end else if (m_ready) begin
                mdl_have = 0;
            end
            if (clear_cnt) begin
                mdl_beats = 0; mdl_bits = 0;
            end else if (acc && inj) begin
                if (err_vec != '0) mdl_beats++;
                mdl_bits += $countones(err_vec);
            end
            if (mdl_cont)
                mdl_cont = (mode == 2'b01);
            else if (mdl_left > 0) begin
                if (mode != 2'b10) mdl_left = 0;
                else if (acc) mdl_left--;
            end else if (mode == 2'b01)
                mdl_cont = 1;
            else if (mode == 2'b10 && start)
                mdl_left = int'(burst_len);
        end
    end

    function automatic longint exp_bits(input int w);
`ifdef RIFL_ERR_STATS_EN
        return sat(mdl_bits, w);
`else
        return 0;
`endif
    endfunction

    // Per-cycle comparison against the model, away from the clock edge.
    always @(negedge clk) begin
        #2;
        if (!rst) begin
            chk("m_valid", DW'(m_valid), DW'(mdl_have));
            if (mdl_have) chk("m_data", m_data, mdl_data);
            chk("s_ready", DW'(s_ready), DW'(!mdl_have || m_ready));
            chk("busy", DW'(busy), DW'(mdl_cont || mdl_left > 0));
            chk("inj_beats", DW'(inj_beats), DW'(sat(mdl_beats, 32)));
            chk("inj_bits", DW'(inj_bits), DW'(exp_bits(32)));
            chk("sm_beats", DW'(sm_beats), DW'(sat(mdl_beats, 2)));
            chk("sm_bits", DW'(sm_bits), DW'(exp_bits(2)));
        end
    end

    // Sink readiness: random when enabled, otherwise always ready.
    always @(negedge clk) m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;

    // ---------------- stimulus helpers ----------------
    task automatic send(input int n, input logic [DW-1:0] base, input logic [DW-1:0] err);
        for (int i = 0; i < n; i++) begin
            bit done = 0;
            int budget = 0;
            while (!done) begin
                @(negedge clk);
                s_valid = 1'b1; s_data = base + DW'(i); err_vec = err;
                #1;
                done = s_ready;
                budget++;
                if (!done && budget > 200) begin
                    checks++; errors++;
                    $display("FAIL send_timeout: beat %0d not accepted after %0d cycles", i, budget);
                    done = 1;
                end
            end
        end
        @(negedge clk);
        s_valid = 1'b0; err_vec = {$urandom, $urandom};
    endtask

    task automatic drain();
        rand_ready = 1'b0;
        @(negedge clk); s_valid = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic clear_pulse();
        @(negedge clk); clear_cnt = 1'b1;
        @(negedge clk); clear_cnt = 1'b0;
    endtask

    initial begin
        rst = 1'b1; s_data = '0; s_valid = 1'b0; m_ready = 1'b1; err_vec = '0;
        mode = 2'b00; start = 1'b0; burst_len = '0; clear_cnt = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_m_valid", DW'(m_valid), '0);
        chk("rst_m_data", m_data, '0);
        chk("rst_busy", DW'(busy), '0);
        chk("rst_inj_beats", DW'(inj_beats), '0);
        chk("rst_inj_bits", DW'(inj_bits), '0);
        @(negedge clk); rst = 1'b0;

        // Off: all-ones errors must not touch the data.
        recv.delete();
        send(100, 64'd0, {DW{1'b1}});
        drain();
        chk("off_cnt", DW'(recv.size()), 64'd100);
        for (int i = 0; i < 100 && i < recv.size(); i++) chk("off_data", recv[i], DW'(i));
        chk("off_beats", DW'(inj_beats), '0);
        chk("off_busy", DW'(busy), '0);

        // Reserved mode behaves as off.
        mode = 2'b11; recv.delete();
        send(3, 64'h1000, 64'hF0);
        drain();
        chk("rsv_data", recv[0], 64'h1000);
        chk("rsv_busy", DW'(busy), '0);

        // Continuous, LSB flip, random backpressure.
        mode = 2'b01; clear_pulse(); recv.delete();
        rand_ready = 1'b1;
        send(100, 64'h2000, 64'h1);
        drain();
        mode = 2'b00;
        @(negedge clk);
        chk("cont_cnt", DW'(recv.size()), 64'd100);
        for (int i = 0; i < 100 && i < recv.size(); i++) chk("cont_data", recv[i], (64'h2000 + DW'(i)) ^ 64'h1);
        chk("cont_beats", DW'(inj_beats), 64'd100);
        chk("cont_sm_sat", DW'(sm_beats), 64'd3);

        // Burst of 5 on the low byte.
        clear_pulse(); recv.delete();
        @(negedge clk); mode = 2'b10; burst_len = BW'(5); start = 1'b1;
        @(negedge clk); start = 1'b0;
        send(8, 64'h3000, 64'hFF);
        drain();
        for (int i = 0; i < 8 && i < recv.size(); i++)
            chk("burst5_data", recv[i], (64'h3000 + DW'(i)) ^ ((i < 5) ? 64'hFF : 64'h0));
        chk("burst5_busy", DW'(busy), '0);
        chk("burst5_beats", DW'(inj_beats), 64'd5);
`ifdef RIFL_ERR_STATS_EN
        chk("burst5_bits", DW'(inj_bits), 64'd40);
`else
        chk("burst5_bits", DW'(inj_bits), 64'd0);
`endif

        // Zero-length burst arms nothing.
        recv.delete();
        @(negedge clk); burst_len = '0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); #2;
        chk("blen0_busy", DW'(busy), '0);
        send(3, 64'h4000, 64'hFF);
        drain();
        chk("blen0_data", recv[2], 64'h4002);

        // Burst of 10 aborted after 3 beats.
        clear_pulse(); recv.delete();
        @(negedge clk); burst_len = BW'(10); start = 1'b1;
        @(negedge clk); start = 1'b0;
        send(3, 64'h5000, 64'h0F);
        mode = 2'b00;
        @(negedge clk); #2;
        chk("abort_busy", DW'(busy), '0);
        send(3, 64'h5003, 64'h0F);
        drain();
        for (int i = 0; i < 6 && i < recv.size(); i++)
            chk("abort_data", recv[i], (64'h5000 + DW'(i)) ^ ((i < 3) ? 64'h0F : 64'h0));
        chk("abort_beats", DW'(inj_beats), 64'd3);

        // Saturation of the 2-bit counter, then clear against a corrupted beat.
        mode = 2'b01; clear_pulse();
        send(2, 64'h6000, 64'h1);
        drain();
        chk("sat_pre", DW'(sm_beats), 64'd2);
        send(5, 64'h6010, 64'h1);
        drain();
        chk("sat_hold", DW'(sm_beats), 64'd3);
        chk("sat_big", DW'(inj_beats), 64'd7);
        @(negedge clk); s_valid = 1'b1; s_data = 64'h7000; err_vec = 64'h3; clear_cnt = 1'b1;
        @(negedge clk); s_valid = 1'b0; clear_cnt = 1'b0; #2;
        chk("clr_prio_big", DW'(inj_beats), '0);
        chk("clr_prio_sm", DW'(sm_beats), '0);
        mode = 2'b00;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
